// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared state encoding and default sizes for the register file
package regfile_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } regfile_state_t;

  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_ADDR_W = 5;

endpackage

// File: rtl/regfile_init_seq.sv
// rtl/regfile_init_seq.sv - post-reset clear sequencer, one entry per cycle
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REGFILE_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_ready,
  output logic              o_clr_en,
  output logic [ADDR_W-1:0] o_clr_addr
);

  regfile_state_t    r_state;
  logic [ADDR_W-1:0] r_cnt;

  // Leaving INIT on the last entry means cnt never has to wrap in use.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + ADDR_W'(1);
          if (r_cnt == {ADDR_W{1'b1}}) r_state <= ST_READY;
        end
        ST_READY: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_ready    = (r_state == ST_READY);
  assign o_clr_en   = (r_state == ST_INIT);
  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - 1W/2R register file with reset clear; REGFILE_BYPASS_EN adds write-to-read forwarding
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_regwr,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [ADDR_W-1:0] i_ra,
  input  logic [ADDR_W-1:0] i_rb,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_outa,
  output logic [DATA_W-1:0] o_outb,
  output logic              o_ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_ready;
  logic              w_clr_en;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_rd_zero;
  logic              w_ra_zero;
  logic              w_rb_zero;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_vala;
  logic [DATA_W-1:0] w_valb;

  regfile_init_seq #(.ADDR_W(ADDR_W)) u_init_seq (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .o_ready    (w_ready),
    .o_clr_en   (w_clr_en),
    .o_clr_addr (w_clr_addr)
  );

  assign w_rd_zero = (ZERO_REG != 0) && (i_rd == '0);
  assign w_ra_zero = (ZERO_REG != 0) && (i_ra == '0);
  assign w_rb_zero = (ZERO_REG != 0) && (i_rb == '0);
  assign w_wr_en   = w_ready && i_regwr && !i_rst && !w_rd_zero;

  // Clear port wins; the write port is only ever enabled once READY.
  always_ff @(posedge i_clk) begin
    if (w_clr_en && !i_rst) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_en) begin
      r_mem[i_rd] <= i_data;
    end
  end

  always_comb begin
    w_vala = r_mem[i_ra];
    w_valb = r_mem[i_rb];
`ifdef REGFILE_BYPASS_EN
    if (w_ready && i_regwr && !w_rd_zero && (i_ra == i_rd)) w_vala = i_data;
    if (w_ready && i_regwr && !w_rd_zero && (i_rb == i_rd)) w_valb = i_data;
`endif
    if (w_ra_zero || !w_ready) w_vala = '0;
    if (w_rb_zero || !w_ready) w_valb = '0;
  end

  assign o_outa  = w_vala;
  assign o_outb  = w_valb;
  assign o_ready = w_ready;

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the fixed 32×32 register file for the single-cycle processor datapath. Provides one synchronous write port and two combinational read ports over `2**ADDR_W` entries of `DATA_W` bits, with an optional hardwired-zero entry 0. Adds a synchronous reset that clears every entry through a one-entry-per-cycle init sequencer, plus a `ready` flag. Sits between instruction decode and the ALU, in the same position as the existing register file.

## Interface
- `DATA_W`, 32, entry width in bits
- `ADDR_W`, 5, address width; depth `DEPTH = 2**ADDR_W`
- `ZERO_REG`, 1, when 1, entry 0 always reads 0 and ignores writes
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `regwr`  in  1  write enable
- `rd`  in  ADDR_W  write address
- `ra`  in  ADDR_W  read address, port A
- `rb`  in  ADDR_W  read address, port B
- `data`  in  DATA_W  write data
- `outa`  out  DATA_W  read data, port A
- `outb`  out  DATA_W  read data, port B
- `ready`  out  1  high when init is complete and writes are accepted

## Operation
- Two states: `INIT`, `READY`. A clear counter `cnt` is `ADDR_W` bits wide.
- **Reset:** a rising edge with `rst=1` forces `INIT` and `cnt=0`, from any state, including mid-sequence or mid-write.
- **INIT:**
  - Each edge with `rst=0` writes 0 to `entry[cnt]` and then increments `cnt`.
  - The edge that clears `entry[DEPTH-1]` moves the state to `READY`.
  - While `rst` stays high, `cnt` holds at 0.
  - `regwr` is ignored.
  - `outa` and `outb` are forced to 0.
- **READY, write:** on an edge with `regwr=1`, `entry[rd] <= data`. When `ZERO_REG=1` and `rd=0`, the write is dropped.
- **READY, read:**
  - `outa = entry[ra]` and `outb = entry[rb]`, both purely combinational.
  - When `ZERO_REG=1`, address 0 reads 0.
- **Reads in the same cycle as a write:**
  - `ra==rb` is legal; both ports return the same value.
  - A read of `rd` in the write cycle returns the old value, unless the bypass feature below is enabled.
- **Counter wrap:** `cnt` never wraps in use, because the state leaves `INIT` at `DEPTH-1`. No other counters exist.

## Timing
- Read latency: 0 cycles (combinational from `ra`/`rb`).
- Write latency: 1 edge. A value written at edge N is visible on the read ports after edge N.
- Init latency: `ready` rises exactly `DEPTH` edges after the first edge sampling `rst=0`. With `ADDR_W=5`, that is 32 edges.
- Output values from the first reset edge until `ready` rises:
  - `ready=0`
  - `outa=0`, `outb=0`
- `ready` is registered and has no glitches. It stays 1 until the next `rst` edge.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- **Defined:** write-to-read forwarding is enabled.
  - Forwarding condition: `ready=1`, `regwr=1`, `ra==rd`, and the entry is not the zero register.
  - When the condition holds, `outa=data` combinationally in the same cycle.
  - Port B uses the same logic with `rb`.
- **Not defined:** there is no forwarding path. Reads of `rd` in the write cycle return the pre-write value.

## Structure
- Shared package `regfile_pkg` holds:
  - The state encoding: `ST_INIT=1'b0`, `ST_READY=1'b1`.
  - The defaults: `REGFILE_DATA_W=32`, `REGFILE_ADDR_W=5`.
- Sub-module `regfile_init_seq` holds:
  - The state FSM and `cnt`.
  - Outputs: `ready`, `clr_en`, `clr_addr`.
- The top level holds:
  - The storage array.
  - The merge between the write port and the clear port. The clear port has priority, and only the clear port is active in `INIT`.
  - The read muxes and the optional bypass.

## Test plan
- **Reset and init:**
  - Stimulus: `rst=1` for 3 edges, then 0.
  - Response: `ready=0` for 32 edges, then 1. Every `ra` reads `0x00000000`.
- **Write then read:**
  - Stimulus: write `0xDEADBEEF` to r5. Next cycle `ra=5`, `rb=0`.
  - Response: `outa=0xDEADBEEF`, `outb=0`.
- **Zero register:**
  - Stimulus: write `0x12345678` to r0 with `ZERO_REG=1`.
  - Response: `ra=0` reads 0.
  - Repeat with `ZERO_REG=0`; response: `ra=0` reads `0x12345678`.
- **Same-cycle read of `rd`:**
  - Stimulus: r7 holds `0x1`. Write `0x2` to r7 with `ra=7` in the same cycle.
  - Response: `outa=0x2` with `REGFILE_BYPASS_EN`, `0x1` without.
- **Write during INIT:**
  - Stimulus: `regwr=1`, `rd=3`, `data=0xFF` during the init sequence.
  - Response: after `ready`, r3 reads 0.
- **Reset mid-init and mid-operation:**
  - Stimulus: assert `rst` at init edge 10, and separately after r9 has been written with `0xAA`.
  - Response: `ready` drops on the next edge, the 32-edge sequence restarts, and r9 reads 0 afterwards.
